// File: rtl/alu_serial.sv
// Bit-serial 32-bit ALU: one result bit per cycle, LSB first, with a final
// cycle that resolves SLT and registers the flags. Start-to-done is 33 cycles.
module alu_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [3:0]  ALU_control,
    output logic [31:0] result,
    output logic        zero,
    output logic        cout,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_ctrl;
    logic [4:0]  r_idx;
    logic        r_carry;
    logic        r_c31_in;
    logic        r_set;

    logic        w_supported;
    logic        w_arith;
    logic        w_slt;
    logic        w_a_bit;
    logic        w_b_bit;
    logic        w_sum;
    logic        w_carry_out;
    logic        w_res_raw;
    logic        w_res_bit;
    logic        w_ovf;
    logic [31:0] w_final;

    function automatic logic f_supported(input logic [3:0] ctrl);
        logic ok;
        case (ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1100, 4'b1101: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Per-bit datapath for the bit currently selected by r_idx.
    always_comb begin
        w_supported = f_supported(r_ctrl);
        // Among supported codes, only ADD/SUB/SLT have operation bit 1 set.
        w_arith     = w_supported & r_ctrl[1];
        w_slt       = w_supported & (r_ctrl[1:0] == 2'b11);
        w_a_bit     = r_a[r_idx] ^ r_ctrl[3];
        w_b_bit     = r_b[r_idx] ^ r_ctrl[2];
        w_sum       = w_a_bit ^ w_b_bit ^ r_carry;
        w_carry_out = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));
        case (r_ctrl[1:0])
            2'b00:   w_res_raw = w_a_bit & w_b_bit;
            2'b01:   w_res_raw = w_a_bit | w_b_bit;
            2'b10:   w_res_raw = w_sum;
            2'b11:   w_res_raw = 1'b0;
            default: w_res_raw = 1'b0;
        endcase
        w_res_bit = w_supported ? w_res_raw : 1'b0;
    end

    // Final-cycle result and overflow; SLT corrects the sign bit by overflow.
    always_comb begin
        w_ovf   = r_c31_in ^ r_carry;
        w_final = result;
        if (w_slt) begin
            w_final[0] = r_set ^ w_ovf;
        end else begin
            w_final[0] = result[0];
        end
    end

    // Control FSM, serial accumulation and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_ctrl   <= 4'd0;
            r_idx    <= 5'd0;
            r_carry  <= 1'b0;
            r_c31_in <= 1'b0;
            r_set    <= 1'b0;
            result   <= 32'd0;
            zero     <= 1'b1;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= src1;
                        r_b     <= src2;
                        r_ctrl  <= ALU_control;
                        r_idx   <= 5'd0;
                        r_carry <= ALU_control[2];
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    result[r_idx] <= w_res_bit;
                    r_carry       <= w_carry_out;
                    if (r_idx == 5'd31) begin
                        r_c31_in <= r_carry;
                        r_set    <= w_sum;
                        r_state  <= FIN;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                FIN: begin
                    result   <= w_final;
                    // Unsupported codes report every flag as 0, zero included.
                    zero     <= w_supported ? (w_final == 32'd0) : 1'b0;
                    cout     <= w_arith ? r_carry : 1'b0;
                    overflow <= w_arith ? w_ovf : 1'b0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_idx    <= 5'd0;
                    r_state  <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_idx   <= 5'd0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: issued ops push expectations, a negedge
// monitor pops and checks them whenever done is seen.
module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic [3:0]  ALU_control = 4'd0;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic        busy;
    logic        done;

    alu_serial dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        int          e0;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: checks every done pulse against the oldest pending expectation.
    always @(negedge clk) begin
        if (prev_done) chk("done_width", {31'd0, done}, 32'd0);
        prev_done = done;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pending op");
            end else begin
                m_e = q.pop_front();
                chk("result",   result, m_e.res);
                chk("zero",     {31'd0, zero}, {31'd0, m_e.z});
                chk("cout",     {31'd0, cout}, {31'd0, m_e.c});
                chk("overflow", {31'd0, overflow}, {31'd0, m_e.v});
                chk("latency",  cyc - m_e.e0, 32'd33);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 200 cycles");
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending ops expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                         input logic [31:0] res, input logic z, input logic c, input logic v);
        wait_idle();
        src1 = a;
        src2 = b;
        ALU_control = ctrl;
        start = 1'b1;
        q.push_back('{res, z, c, v, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_result"},   result, 32'd0);
        chk({tag, "_zero"},     {31'd0, zero}, 32'd1);
        chk({tag, "_cout"},     {31'd0, cout}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
        chk({tag, "_done"},     {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1);
        issue(32'd5,        32'd5,        4'b0110, 32'h00000000, 1'b1, 1'b1, 1'b0);
        issue(32'h80000000, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b1, 1'b1);
        issue(32'd3,        32'hFFFFFFFF, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b0);
        issue(32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        issue(32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
        issue(32'hF0F0F0F0, 32'hFF00FF00, 4'b1100, 32'h000F000F, 1'b0, 1'b0, 1'b0);
        issue(32'hF0F0F0F0, 32'hFF00FF00, 4'b1101, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0);
        issue(32'h12345678, 32'h9ABCDEF0, 4'b1010, 32'h00000000, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // Start and operand changes mid-operation must be ignored.
        issue(32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        src1 = 32'd0;
        src2 = 32'd0;
        ALU_control = 4'b0111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start held high: three back-to-back ops, 34 cycles apart.
        wait_idle();
        src1 = 32'd2;
        src2 = 32'd3;
        ALU_control = 4'b0010;
        start = 1'b1;
        q.push_back('{32'd5, 1'b0, 1'b0, 1'b0, cyc + 1});
        q.push_back('{32'd5, 1'b0, 1'b0, 1'b0, cyc + 35});
        q.push_back('{32'd5, 1'b0, 1'b0, 1'b0, cyc + 69});
        repeat (70) @(negedge clk);
        start = 1'b0;
        wait_drain();

        repeat (5) @(negedge clk);
        chk("hold_result", result, 32'd5);
        chk("hold_zero",   {31'd0, zero}, 32'd0);
        chk("idle_busy",   {31'd0, busy}, 32'd0);

        // Reset mid-ADD: outputs drop immediately and no done follows.
        src1 = 32'h11111111;
        src2 = 32'h22222222;
        ALU_control = 4'b0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd2, 32'd3, 4'b0010, 32'd5, 1'b0, 1'b0, 1'b0);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port: src1  input  32  operand A; captured on accepted start.
REQ-005 SHALL have port: src2  input  32  operand B; captured on accepted start.
REQ-006 SHALL have port: ALU_control  input  4  op code; captured on accepted start.
REQ-007 SHALL have port: result  output  32  registered result.
REQ-008 SHALL have port: zero  output  1  result == 0.
REQ-009 SHALL have port: cout  output  1  carry out of bit 31.
REQ-010 SHALL have port: overflow  output  1  signed overflow.
REQ-011 SHALL have port: busy  output  1  operation in progress.
REQ-012 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL decode ALU_control as: bit3 = A_invert, bit2 = B_invert, bits[1:0] = operation (00 AND, 01 OR, 10 ADD, 11 LESS).
REQ-014 SHALL support exactly these codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
  - 1101 NAND
REQ-015 SHALL treat any other code as unsupported: result = 0, all flags 0, same latency.
REQ-016 SHALL use FSM states IDLE -> RUN -> FIN -> IDLE. It SHALL enter IDLE at reset.
REQ-017 In IDLE with start = 1 at edge E0, SHALL:
  - latch src1, src2 and ALU_control;
  - clear the bit index to 0;
  - load the carry register with B_invert;
  - go to RUN.
REQ-018 In RUN, SHALL process one bit per cycle, LSB first.
REQ-019 For bit i, SHALL compute a = A_invert ? ~src1[i] : src1[i] and b = B_invert ? ~src2[i] : src2[i], then sum = a ^ b ^ carry.
REQ-020 SHALL write bit i of the result register at edge E(i+1), and update the carry with the carry-out of bit i.
REQ-021 For operation 11, SHALL write 0 into result bits 31..1. The set value SHALL be the bit-31 sum.
REQ-022 After bit 31 is written at E32, SHALL go to FIN.
REQ-023 In FIN, at edge E33, SHALL:
  - for SLT only, write result[0] = set ^ overflow (correct signed compare);
  - register zero, cout and overflow;
  - assert done;
  - return to IDLE.
REQ-024 For ADD, SUB and SLT, SHALL set cout = carry out of bit 31 and overflow = carry-in(bit31) ^ carry-out(bit31). For logic ops, both SHALL be 0.
REQ-025 SHALL hold zero equal to the final 32-bit result == 0, including for SLT.
REQ-026 SHALL hold busy = 1 from E0 until E33, and busy = 0 after E33. Total latency: start edge to done = 33 cycles.
REQ-027 SHALL assert done for exactly one cycle.
REQ-028 SHALL hold result and flags stable from E33 until the next accepted start.
REQ-029 SHALL ignore start while busy = 1; operand or control changes during busy SHALL have no effect.
REQ-030 SHALL accept start asserted in the cycle done = 1 (state IDLE) as a back-to-back operation.
REQ-031 SHALL leave intermediate result bits and flags unspecified to observers while busy = 1, with zero, cout and overflow held at their previous values.

Reset
REQ-032 When rst_n = 0, SHALL immediately and asynchronously force:
  - state = IDLE;
  - result = 0;
  - zero = 1, cout = 0, overflow = 0;
  - busy = 0, done = 0;
  - bit index = 0, carry = 0.
REQ-033 Reset asserted mid-operation SHALL abort the operation. No done SHALL follow, and the first start after reset release SHALL be accepted normally.

Verification
REQ-034 ADD: src1 = 0x7FFFFFFF, src2 = 0x00000001, ctrl 0010 -> after 33 cycles result = 0x80000000, overflow = 1, cout = 0, zero = 0, done pulses once.
REQ-035 SUB: src1 = 5, src2 = 5, ctrl 0110 -> result = 0, zero = 1, cout = 1, overflow = 0.
REQ-036 SLT: src1 = 0x80000000, src2 = 0x00000001, ctrl 0111 -> result = 0x00000001 (overflow case). Then src1 = 3, src2 = 0xFFFFFFFF -> result = 0, zero = 1.
REQ-037 Logic ops: src1 = 0xF0F0F0F0, src2 = 0xFF00FF00 under 0000/0001/1100/1101 -> 0xF000F000, 0xFFF0FFF0, 0x000F000F, 0x0FFF0FFF, with cout = overflow = 0.
REQ-038 Handshake and error cases:
  - start pulsed at cycle 10 of a busy op -> ignored, single done;
  - start held high -> back-to-back ops every 34 cycles;
  - ctrl 1010 -> result = 0, done at 33.
REQ-039 Reset: rst_n low at cycle 17 of an ADD -> outputs immediately at reset values, no done. A new ADD 2 + 3 after release -> result = 5.
